mem_arbiter_rr: RTL and testbench

Parametrised round-robin arbiter that shares one single-port synchronous RAM between `NCORES` processor cores over packed per-core buses. It replaces the fixed three-core, 8-bit controller: address and data widths and core count are generic, and it adds a synchronous reset, zero-bubble handover, per-core read-valid pulses with in-flight read tagging, and an optional burst cap. Sits between the core array and the shared data RAM.

---
 rtl/mem_arbiter_rr.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_rr
// Description : Round-robin arbiter sharing one single-port synchronous RAM
//               between NCORES cores, with tagged 2-stage read return.
//               Optional burst cap enabled by MEMARB_BURST_LIMIT_EN.
// Revision    : 1.0
// ============================================================================
module mem_arbiter_rr #(
    parameter int NCORES    = 3,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    rden,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES*AW-1:0] Address,
    input  logic [NCORES*DW-1:0] Din,
    input  logic [DW-1:0]        RAMq,
    output logic [NCORES-1:0]    acq,
    output logic [NCORES-1:0]    rvalid,
    output logic [NCORES*DW-1:0] Dq,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren
);

    localparam int                c_IDX_W    = $clog2(NCORES);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NCORES - 1);
    localparam logic [NCORES-1:0]  c_ONE      = NCORES'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_last;
    logic                 r_t1_valid;
    logic [c_IDX_W-1:0]   r_t1_idx;
    logic                 r_t2_valid;
    logic [c_IDX_W-1:0]   r_t2_idx;

    logic [NCORES-1:0]    w_req;
    logic                 w_rr_found;
    logic [c_IDX_W-1:0]   w_rr_idx;
    logic                 w_expired;
    logic                 w_keep;
    logic                 w_grant;
    logic [c_IDX_W-1:0]   w_win;

    assign w_req = rden | wren;

    // Descending scan so the nearest requester after r_last is assigned last and wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_last;
        for (int off = NCORES; off >= 1; off--) begin
            if (w_req[(int'(r_last) + off) % NCORES]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = c_IDX_W'((int'(r_last) + off) % NCORES);
            end
        end
    end

`ifdef MEMARB_BURST_LIMIT_EN
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    logic [c_CNT_W-1:0] r_burst_cnt;
    logic               w_others;

    assign w_others  = |(w_req & ~(c_ONE << r_last));
    assign w_expired = (r_burst_cnt >= c_CNT_W'(MAX_BURST)) && w_others;

    // Counts cycles of the current ownership; restarts on every new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (w_grant) begin
            if (w_keep) begin
                if (r_burst_cnt < c_CNT_W'(MAX_BURST)) begin
                    r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
                end
            end else begin
                r_burst_cnt <= c_CNT_W'(1);
            end
        end else begin
            r_burst_cnt <= '0;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    assign w_keep  = (r_state == ST_OWN) && w_req[r_last] && !w_expired;
    assign w_grant = w_keep || w_rr_found;
    assign w_win   = w_keep ? r_last : w_rr_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= c_LAST_RST;
            acq        <= '0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
            r_t1_valid <= 1'b0;
            r_t1_idx   <= '0;
            r_t2_valid <= 1'b0;
            r_t2_idx   <= '0;
            rvalid     <= '0;
            Dq         <= '0;
        end else begin
            if (w_grant) begin
                r_state    <= ST_OWN;
                r_last     <= w_win;
                acq        <= c_ONE << w_win;
                RAMAddress <= Address[int'(w_win)*AW +: AW];
                RAMDin     <= Din[int'(w_win)*DW +: DW];
                RAMwren    <= wren[w_win];
                // A simultaneous write suppresses the read.
                r_t1_valid <= rden[w_win] & ~wren[w_win];
                r_t1_idx   <= w_win;
            end else begin
                r_state    <= ST_IDLE;
                acq        <= '0;
                RAMwren    <= 1'b0;
                r_t1_valid <= 1'b0;
            end

            r_t2_valid <= r_t1_valid;
            r_t2_idx   <= r_t1_idx;

            rvalid <= '0;
            if (r_t2_valid) begin
                rvalid[r_t2_idx]             <= 1'b1;
                Dq[int'(r_t2_idx)*DW +: DW] <= RAMq;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter_rr
// Description : Directed self-checking bench for mem_arbiter_rr with a RAM
//               model and a read-return scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_mem_arbiter_rr;

    localparam int NC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rden, wren;
    logic [23:0] Address, Din;
    logic [7:0]  RAMq;
    logic [2:0]  acq, rvalid;
    logic [23:0] Dq;
    logic [7:0]  RAMAddress, RAMDin;
    logic        RAMwren;

    mem_arbiter_rr #(.NCORES(NC), .AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(Address),
        .Din(Din), .RAMq(RAMq), .acq(acq), .rvalid(rvalid), .Dq(Dq),
        .RAMAddress(RAMAddress), .RAMDin(RAMDin), .RAMwren(RAMwren)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    logic [7:0]  ram[256];
    logic [7:0]  model_mem[256];
    logic [23:0] exp_dq;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    // Single-port synchronous RAM, registered read
    always @(posedge clk) begin
        if (RAMwren) ram[RAMAddress] <= RAMDin;
        RAMq <= ram[RAMAddress];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rvalid !== 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {29'd0, rvalid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rvalid_idx", {29'd0, rvalid}, 32'd1 << mon_e.idx);
                    exp_dq[mon_e.idx*8 +: 8] = mon_e.data;
                end
            end
            chk("dq_slices", {8'd0, Dq}, {8'd0, exp_dq});
        end
    end

    task automatic cyc(input string tag, input logic [2:0] exp_acq);
        int         w;
        logic [7:0] a, d;
        logic       wr, rd;
        w  = -1;
        a  = 8'h00;
        d  = 8'h00;
        wr = 1'b0;
        rd = 1'b0;
        for (int i = 0; i < NC; i++) if (exp_acq[i]) w = i;
        if (w >= 0) begin
            a  = Address[w*8 +: 8];
            d  = Din[w*8 +: 8];
            wr = wren[w];
            rd = rden[w];
            if (rd && !wr) sb.push_back('{w, model_mem[a]});
            if (wr) model_mem[a] = d;
        end
        @(posedge clk); #1;
        chk({tag, "_acq"}, {29'd0, acq}, {29'd0, exp_acq});
        if (w >= 0) begin
            chk({tag, "_addr"}, {24'd0, RAMAddress}, {24'd0, a});
            chk({tag, "_wren"}, {31'd0, RAMwren}, {31'd0, wr});
            if (wr) chk({tag, "_din"}, {24'd0, RAMDin}, {24'd0, d});
        end else begin
            chk({tag, "_wren_idle"}, {31'd0, RAMwren}, 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acq"},    {29'd0, acq},        32'd0);
        chk({tag, "_rvalid"}, {29'd0, rvalid},     32'd0);
        chk({tag, "_dq"},     {8'd0, Dq},          32'd0);
        chk({tag, "_raddr"},  {24'd0, RAMAddress}, 32'd0);
        chk({tag, "_rdin"},   {24'd0, RAMDin},     32'd0);
        chk({tag, "_rwren"},  {31'd0, RAMwren},    32'd0);
    endtask

    initial begin
        logic [2:0] exp_b;
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst = 1'b1; rden = '0; wren = '0; Address = '0; Din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        exp_dq = '0;
        mon_en = 1'b1;
        rst    = 1'b0;

        // All three read; core 0 first, then handover without a gap
        rden = 3'b111; Address = {8'h30, 8'h20, 8'h10};
        cyc("rr0", 3'b001);
        cyc("rr0b", 3'b001);
        rden = 3'b110;
        cyc("rr1", 3'b010);
        rden = 3'b100;
        cyc("rr2", 3'b100);
        rden = 3'b000;
        repeat (3) cyc("drain1", 3'b000);

        // Core 1 write then read-back with latency check
        wren = 3'b010; Address[15:8] = 8'h40; Din[15:8] = 8'hA5;
        cyc("wr1", 3'b010);
        wren = 3'b000; rden = 3'b010;
        cyc("rd1", 3'b010);
        rden = 3'b000;
        cyc("lat_e1", 3'b000);
        chk("rvalid_e1", {29'd0, rvalid}, 32'd0);
        cyc("lat_e2", 3'b000);
        chk("rvalid_e2", {29'd0, rvalid}, 32'b010);
        chk("dq1_a5", {24'd0, Dq[15:8]}, 32'hA5);
        repeat (2) cyc("drain2", 3'b000);

        // Core 0 single read, immediate handover to core 2
        rden = 3'b001; Address[7:0] = 8'h05;
        cyc("c0_once", 3'b001);
        rden = 3'b100; Address[23:16] = 8'h07;
        cyc("c2_next", 3'b100);
        rden = 3'b000;
        repeat (3) cyc("drain3", 3'b000);

        // Simultaneous read+write: write only, no read return
        rden = 3'b010; wren = 3'b010; Address[15:8] = 8'h41; Din[15:8] = 8'h3C;
        cyc("rw1", 3'b010);
        rden = 3'b000; wren = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cyc("rw_idle", 3'b000);
            chk("rw_no_rvalid", {29'd0, rvalid}, 32'd0);
        end
        rden = 3'b010;
        cyc("rd41", 3'b010);
        rden = 3'b000;
        repeat (3) cyc("drain4", 3'b000);

        // Reset while a read is in flight
        rden = 3'b001; Address[7:0] = 8'h50;
        cyc("pre_rst", 3'b001);
        rden = 3'b000; rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midrst");
        sb.delete();
        exp_dq = '0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_rvalid", {29'd0, rvalid}, 32'd0);
        end

        // Cores 0 and 2 request continuously
        rden = 3'b101; Address[7:0] = 8'h60; Address[23:16] = 8'h62;
        for (int i = 0; i < 12; i++) begin
`ifdef MEMARB_BURST_LIMIT_EN
            exp_b = ((i / 4) % 2 == 1) ? 3'b100 : 3'b001;
`else
            exp_b = 3'b001;
`endif
            cyc("burst", exp_b);
        end
        rden = 3'b000;
        repeat (3) cyc("drain5", 3'b000);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
